// File: rtl/shift_engine_pkg.sv
// shift_engine_pkg: shared types for the shift engine (burst op codes and FSM states)
package shift_engine_pkg;
  typedef enum logic [1:0] {SHIFT1 = 2'd0, SHIFT2 = 2'd1, ROT1 = 2'd2, ROT2 = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/shift_engine_if.sv
// shift_engine_if: control/data bundle of the shift engine
//   master (driver side): load, d, start, op, dir, count, step_en, ser_in -> engine
//   slave  (engine side): q, ser_out_l, ser_out_r, busy, done, remaining -> driver
interface shift_engine_if
  import shift_engine_pkg::*;
#(
  parameter int N  = 26,
  parameter int CW = $clog2(N + 1)
);
  logic          load;
  logic [N-1:0]  d;
  logic          start;
  op_t           op;
  logic          dir;
  logic [CW-1:0] count;
  logic          step_en;
  logic [1:0]    ser_in;
  logic [N-1:0]  q;
  logic [1:0]    ser_out_l;
  logic [1:0]    ser_out_r;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;
  modport master (
    output load, d, start, op, dir, count, step_en, ser_in,
    input  q, ser_out_l, ser_out_r, busy, done, remaining
  );
  modport slave (
    input  load, d, start, op, dir, count, step_en, ser_in,
    output q, ser_out_l, ser_out_r, busy, done, remaining
  );
endinterface

// File: rtl/shift_step_counter.sv
// shift_step_counter: burst step counter (load, decrement, zero/last flags)
//   clk, rst_n     : clock, async active-low reset
//   i_load/i_count : load a new step count
//   i_dec          : consume one step
//   o_remaining    : steps left; o_zero when none left; o_last when one left
module shift_step_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_count,
  input  logic          i_dec,
  output logic [CW-1:0] o_remaining,
  output logic          o_zero,
  output logic          o_last
);
  logic [CW-1:0] r_rem;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rem <= '0;
    else if (i_load) r_rem <= i_count;
    else if (i_dec) r_rem <= r_rem - 1'b1;
  assign o_remaining = r_rem;
  assign o_zero      = r_rem == '0;
  assign o_last      = r_rem == CW'(1);
endmodule

// File: rtl/shift_engine.sv
// shift_engine: N-bit shift/rotate register executing step_en-paced bursts of 1- or 2-bit steps
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of shift_engine_if (load/start/op/dir/count/step_en/ser_in in,
//                q/ser_out_l/ser_out_r/busy/done/remaining out)
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int N  = 26,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_engine_if.slave bus
);
  state_t       r_state, w_next;
  op_t          r_op;
  logic         r_dir;
  logic [N-1:0] r_q;
  logic         w_go, w_step, w_zero, w_last, w_two, w_rot, w_fill1;
  logic [1:0]   w_fill2;
  logic [N-1:0] w_step1, w_step2;
  assign w_go   = r_state == IDLE && bus.start && !bus.load;
  assign w_step = r_state == RUN && bus.step_en && !w_zero;
  shift_step_counter #(.CW(CW)) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_go),
    .i_count     (bus.count),
    .i_dec       (w_step),
    .o_remaining (bus.remaining),
    .o_zero      (w_zero),
    .o_last      (w_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_go ? (bus.count == '0 ? DONE : RUN) : IDLE) :
             r_state == RUN  ? (w_step && w_last ? DONE : RUN) : IDLE;
  always_comb begin
    bus.busy = r_state == RUN;
    bus.done = r_state == DONE;
  end
  // Rotations feed back the bits shifted out; shifts take them from ser_in.
  assign w_two   = r_op == SHIFT2 || r_op == ROT2;
  assign w_rot   = r_op == ROT1 || r_op == ROT2;
  assign w_fill1 = w_rot ? (r_dir ? r_q[0] : r_q[N-1]) : bus.ser_in[0];
  assign w_fill2 = w_rot ? (r_dir ? r_q[1:0] : r_q[N-1:N-2]) : bus.ser_in;
  assign w_step1 = r_dir ? {w_fill1, r_q[N-1:1]} : {r_q[N-2:0], w_fill1};
  assign w_step2 = r_dir ? {w_fill2, r_q[N-1:2]} : {r_q[N-3:0], w_fill2};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q   <= '0;
      r_op  <= SHIFT1;
      r_dir <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.load) r_q <= bus.d;
      else if (w_step) r_q <= w_two ? w_step2 : w_step1;
      if (w_go) begin
        r_op  <= bus.op;
        r_dir <= bus.dir;
      end
    end
  assign bus.q         = r_q;
  assign bus.ser_out_l = r_q[N-1:N-2];
  assign bus.ser_out_r = r_q[1:0];
endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: directed + random bench for shift_engine against an arithmetic reference model
module tb_shift_engine;
  import shift_engine_pkg::*;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  shift_engine_if #(.N(N), .CW(CW)) bus ();
  shift_engine #(.N(N), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  bit running = 1'b1;
  logic [N-1:0] m_q = '0;
  int m_rem = 0;
  int m_phase = 0;
  op_t m_op = SHIFT1;
  logic m_dir = 1'b0;
  function automatic logic [N-1:0] ref_step(input logic [N-1:0] q, input op_t op, input logic dir,
                                            input logic [1:0] ser);
    int k, v, s, r;
    k = (op == SHIFT2 || op == ROT2) ? 2 : 1;
    v = int'(q);
    s = int'(ser) & ((1 << k) - 1);
    if (op == ROT1 || op == ROT2) r = dir ? ((v >> k) | (v << (N - k))) : ((v << k) | (v >> (N - k)));
    else r = dir ? ((v >> k) | (s << (N - k))) : ((v << k) | s);
    return N'(r & ((1 << N) - 1));
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = '0; m_rem = 0; m_phase = 0; m_op = SHIFT1; m_dir = 1'b0;
    end else if (m_phase == 0) begin
      if (bus.load) m_q = bus.d;
      else if (bus.start) begin
        m_op = bus.op; m_dir = bus.dir; m_rem = int'(bus.count);
        m_phase = (m_rem == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (bus.step_en) begin
        m_q = ref_step(m_q, m_op, m_dir, bus.ser_in);
        m_rem--;
        if (m_rem == 0) m_phase = 2;
      end
    end else m_phase = 0;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (running) begin
      chk("model_q", bus.q, m_q);
      chk("model_busy", bus.busy, m_phase == 1);
      chk("model_done", bus.done, m_phase == 2);
      chk("model_remaining", bus.remaining, m_rem);
      chk("model_ser_out_l", bus.ser_out_l, m_q[N-1:N-2]);
      chk("model_ser_out_r", bus.ser_out_r, m_q[1:0]);
    end
  task automatic cyc();
    @(negedge clk);
  endtask
  logic [N-1:0] qe[5] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF8};
  int re[5] = '{2, 2, 1, 1, 0};
  bit be[5] = '{1, 1, 1, 1, 0};
  bit pat[5] = '{1, 0, 1, 0, 1};
  initial begin
    bus.load = 0; bus.d = '0; bus.start = 0; bus.op = SHIFT1; bus.dir = 0;
    bus.count = '0; bus.step_en = 0; bus.ser_in = 2'b00;
    #1 rst_n = 1'b0;
    cyc(); cyc();
    chk("reset_q", bus.q, 0); chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0); chk("reset_rem", bus.remaining, 0);
    rst_n = 1'b1;
    bus.load = 1; bus.d = 8'hA5; cyc(); bus.load = 0;
    chk("load_q", bus.q, 8'hA5); chk("load_busy", bus.busy, 0);
    cyc(); chk("load_done", bus.done, 0);
    bus.start = 1; bus.op = SHIFT2; bus.dir = 0; bus.count = 2; bus.step_en = 1; bus.ser_in = 2'b11;
    cyc(); bus.start = 0; bus.op = ROT2; bus.dir = 1; bus.count = 7;
    chk("sh2_busy0", bus.busy, 1); chk("sh2_rem0", bus.remaining, 2); chk("sh2_q0", bus.q, 8'hA5);
    cyc(); chk("sh2_q1", bus.q, 8'h97); chk("sh2_busy1", bus.busy, 1);
    bus.ser_in = 2'b00;
    cyc(); chk("sh2_q2", bus.q, 8'h5C); chk("sh2_done", bus.done, 1); chk("sh2_busy2", bus.busy, 0);
    cyc(); chk("sh2_done_gone", bus.done, 0);
    bus.load = 1; bus.d = 8'h81; cyc(); bus.load = 0;
    bus.start = 1; bus.op = ROT1; bus.dir = 1; bus.count = 9; bus.step_en = 1;
    cyc(); bus.start = 0;
    for (int i = 0; i < 9; i++) begin
      chk("rot_rem", bus.remaining, 9 - i); chk("rot_busy", bus.busy, 1);
      cyc();
    end
    chk("rot_done", bus.done, 1); chk("rot_q", bus.q, 8'hC0);
    cyc();
    bus.start = 1; bus.op = SHIFT1; bus.dir = 1; bus.count = 3; bus.ser_in = 2'b01;
    cyc(); bus.start = 0;
    chk("tog_rem0", bus.remaining, 3); chk("tog_busy0", bus.busy, 1);
    bus.load = 1; bus.d = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      bus.step_en = pat[i];
      cyc();
      chk("tog_q", bus.q, qe[i]); chk("tog_rem", bus.remaining, re[i]); chk("tog_busy", bus.busy, be[i]);
    end
    bus.load = 0; bus.step_en = 1;
    chk("tog_done", bus.done, 1);
    cyc();
    bus.start = 1; bus.count = 0; cyc(); bus.start = 0;
    chk("zero_done", bus.done, 1); chk("zero_busy", bus.busy, 0); chk("zero_q", bus.q, 8'hF8);
    chk("zero_rem", bus.remaining, 0);
    cyc(); chk("zero_done_gone", bus.done, 0);
    bus.load = 1; bus.start = 1; bus.d = 8'h3C; bus.count = 2; cyc(); bus.load = 0; bus.start = 0;
    chk("prio_q", bus.q, 8'h3C); chk("prio_busy", bus.busy, 0);
    cyc(); chk("prio_busy2", bus.busy, 0); chk("prio_done", bus.done, 0);
    bus.start = 1; bus.op = ROT2; bus.dir = 0; bus.count = 6; cyc(); bus.start = 0;
    cyc(); cyc(); chk("rst_rem4", bus.remaining, 4);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("rst_q", bus.q, 0); chk("rst_busy", bus.busy, 0); chk("rst_rem", bus.remaining, 0);
    chk("rst_done", bus.done, 0);
    cyc(); rst_n = 1'b1; cyc();
    chk("rst_no_done", bus.done, 0); chk("rst_idle", bus.busy, 0);
    bus.load = 1; bus.d = 8'h5A; cyc(); bus.load = 0;
    bus.start = 1; bus.op = SHIFT1; bus.dir = 0; bus.count = 2; bus.ser_in = 2'b00;
    cyc(); bus.start = 0; cyc(); cyc();
    chk("post_rst_q", bus.q, 8'h68); chk("post_rst_done", bus.done, 1);
    cyc();
    for (int i = 0; i < 600; i++) begin
      bus.load = $urandom_range(0, 7) == 0;
      bus.start = $urandom_range(0, 3) == 0;
      bus.d = N'($urandom);
      bus.op = op_t'(2'($urandom_range(0, 3)));
      bus.dir = 1'($urandom_range(0, 1));
      bus.count = CW'($urandom_range(0, 15));
      bus.step_en = $urandom_range(0, 3) != 0;
      bus.ser_in = 2'($urandom_range(0, 3));
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) #2 rst_n = 1'b0;
      cyc();
    end
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 SHALL have parameter N, default 26: register width in bits; legal range N >= 4.
REQ-002 SHALL have parameter CW, default $clog2(N+1): width of the step-count input.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1: parallel load request, honoured only in IDLE.
REQ-006 SHALL have port d  input  N: parallel load data.
REQ-007 SHALL have port start  input  1: begin a burst of shift steps, honoured only in IDLE.
REQ-008 SHALL have port op  input  2: burst mode, latched at start: SHIFT1, SHIFT2, ROT1 or ROT2.
REQ-009 SHALL have port dir  input  1: burst direction, latched at start; 0 = left (toward MSB), 1 = right.
REQ-010 SHALL have port count  input  CW: number of steps in the burst, latched at start.
REQ-011 SHALL have port step_en  input  1: bit-rate tick; one step executes per RUN cycle with step_en high.
REQ-012 SHALL have port ser_in  input  2: serial input; SHIFT1 uses ser_in[0], SHIFT2 uses ser_in[1:0].
REQ-013 SHALL have port q  output  N: register contents.
REQ-014 SHALL have port ser_out_l  output  2: q[N-1:N-2].
REQ-015 SHALL have port ser_out_r  output  2: q[1:0].
REQ-016 SHALL have port busy  output  1: high in RUN.
REQ-017 SHALL have port done  output  1: single-cycle pulse in DONE.
REQ-018 SHALL have port remaining  output  CW: steps still to execute in the current burst.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; DONE SHALL always return to IDLE after one cycle.
REQ-020 In IDLE, load=1 SHALL set q <= d next edge; load SHALL take priority over start in the same cycle, and that start SHALL be dropped.
REQ-021 In IDLE, start=1 with load=0 SHALL latch op, dir and count, set remaining <= count, and go to RUN; count=0 SHALL go directly to DONE with q unchanged.
REQ-022 In RUN, each cycle with step_en=1 SHALL execute one step and decrement remaining; with step_en=0, q and remaining SHALL hold.
REQ-023 The step that brings remaining to 0 SHALL move the FSM to DONE; done SHALL assert in the cycle after the last step.
REQ-024 SHIFT1 left: q <= {q[N-2:0], ser_in[0]}; right: q <= {ser_in[0], q[N-1:1]}.
REQ-025 SHIFT2 left: q <= {q[N-3:0], ser_in[1:0]}; right: q <= {ser_in[1:0], q[N-1:2]}.
REQ-026 ROT1 and ROT2 SHALL rotate q by 1 or 2 bits in dir with no loss of bits; ser_in SHALL be ignored.
REQ-027 load and start SHALL be ignored in RUN and DONE; changes to op, dir or count during a burst SHALL have no effect.
REQ-028 count values above N SHALL be accepted and executed in full; rotation wraps modulo N, and shifts keep streaming ser_in.
REQ-029 remaining SHALL read 0 in IDLE and DONE.
REQ-030 ser_out_l, ser_out_r and busy SHALL be purely combinational from registered state.

Reset
REQ-031 rst_n low SHALL immediately force q = 0, state = IDLE, remaining = 0, busy = 0, done = 0, and clear the latched op, dir and count, regardless of the current state.
REQ-032 A reset during RUN SHALL abort the burst with no done pulse; the first edge after release SHALL behave as IDLE.

Structure
REQ-033 Package shift_engine_pkg SHALL hold the op_t enum (SHIFT1=0, SHIFT2=1, ROT1=2, ROT2=3) and the state_t enum.
REQ-034 The step counter (load count, decrement on step, zero flag) SHALL be the sub-module shift_step_counter; the datapath and FSM SHALL stay in shift_engine.

Verification (N=8)
REQ-035 Reset then load d=8'hA5 in IDLE -> q=8'hA5 after 1 edge; busy=0; done never pulses.
REQ-036 q=8'hA5, start with SHIFT2, left, count=2, step_en=1 constant, ser_in=2'b11 then 2'b00 -> busy for 2 cycles, q=8'h5C, done pulses once on the next cycle.
REQ-037 q=8'h81, ROT1 right, count=9, step_en=1 -> q=8'hC0 at done; remaining counts down 9..1 while busy.
REQ-038 SHIFT1 right, count=3, step_en toggling 1,0,1,0,1 -> exactly 3 steps; busy stays high for 5 cycles; q and remaining hold on step_en=0 cycles.
REQ-039 start with count=0 -> DONE on the next edge, one done pulse, q unchanged; load and start together in IDLE -> load only, FSM stays in IDLE.
REQ-040 rst_n asserted mid-burst with remaining=4 -> q=0, busy=0, remaining=0 immediately; no done pulse; a new burst after release runs normally.
